// File: rtl/shift_reg_tx.sv
// shift_reg_tx: parallel-in, serial-out converter.
// Words arrive over a valid/ready handshake and leave one bit per enabled
// cycle, LSB first, with first/last markers. A one-word holding buffer lets
// back-to-back words stream with no idle bit between them.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no word in the shift register; outputs quiet, i_en ignored
// ST_SHIFT | r_sr[0] is on o_q; r_cnt is the index of that bit in the word
module shift_reg_tx #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  output logic             o_q,
  output logic             o_valid,
  output logic             o_first,
  output logic             o_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [CW-1:0]    r_cnt;

  logic w_ready;
  logic w_accept;
  logic w_at_last;
  logic w_load;
  logic w_advance;

  // The buffer is the only thing that can block a producer; reset also
  // refuses words so nothing sneaks in across the reset boundary.
  assign w_ready   = !r_hold_full && !i_rst;
  assign w_accept  = i_valid && w_ready;
  assign w_at_last = (r_cnt == LAST_IDX);
  assign w_advance = (r_state == ST_SHIFT) && i_en;

  // Load slot: the shift register is empty now, or its last bit is being
  // consumed this cycle and a new word may take its place without a gap.
  assign w_load = (r_state == ST_IDLE) || (w_advance && w_at_last);

  assign o_ready = w_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: at a load slot go to SHIFT only if a word is available,
  // from the buffer first, otherwise straight from the producer.
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      if (r_hold_full || w_accept) begin
        w_state_nxt = ST_SHIFT;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  // Outputs: decoded from registered state only, so they stay steady for
  // any length of i_en stall.
  always_comb begin
    o_valid = 1'b0;
    o_q     = 1'b0;
    o_first = 1'b0;
    o_last  = 1'b0;
    if (r_state == ST_SHIFT) begin
      o_valid = 1'b1;
      o_q     = r_sr[0];
      o_first = (r_cnt == '0);
      o_last  = w_at_last;
    end
  end

  // Datapath: shift register, holding buffer and bit counter. The buffer
  // drains before a fresh word is taken; an accept while the buffer is full
  // cannot occur because o_ready is low then.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_sr        <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
    end else if (w_load && r_hold_full) begin
      r_sr        <= r_hold;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
    end else if (w_load && w_accept) begin
      r_sr  <= i_data;
      r_cnt <= '0;
    end else if (!w_load) begin
      if (w_accept) begin
        r_hold      <= i_data;
        r_hold_full <= 1'b1;
      end
      if (w_advance) begin
        r_sr  <= r_sr >> 1;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_tx.sv
// Testbench for shift_reg_tx: WIDTH=8 and WIDTH=5 instances, scoreboard of
// expected serial bits checked by per-instance monitors on the falling edge.
module tb_shift_reg_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8 instance
  logic       rst8, valid8, en8;
  logic [7:0] data8;
  logic       ready8, q8, ov8, first8, last8;

  shift_reg_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .i_rst(rst8), .i_valid(valid8), .o_ready(ready8),
    .i_data(data8), .i_en(en8), .o_q(q8), .o_valid(ov8),
    .o_first(first8), .o_last(last8)
  );

  // WIDTH=5 instance
  logic       rst5, valid5, en5;
  logic [4:0] data5;
  logic       ready5, q5, ov5, first5, last5;

  shift_reg_tx #(.WIDTH(5)) dut5 (
    .clk(clk), .i_rst(rst5), .i_valid(valid5), .o_ready(ready5),
    .i_data(data5), .i_en(en5), .o_q(q5), .o_valid(ov5),
    .o_first(first5), .o_last(last5)
  );

  // Expected serial stream entries: {q, first, last}
  logic [2:0] sb8[$];
  logic [2:0] sb5[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push8(input logic [7:0] w);
    for (int i = 0; i < 8; i++) sb8.push_back({w[i], (i == 0), (i == 7)});
  endtask

  task automatic push5(input logic [4:0] w);
    for (int i = 0; i < 5; i++) sb5.push_back({w[i], (i == 0), (i == 4)});
  endtask

  // Move to the next cycle; inputs set after this take effect at the
  // following rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare every presented bit; pop only when it is consumed.
  always @(negedge clk) begin
    if (ov8 === 1'b1) begin
      checks++;
      if (sb8.size() == 0) begin
        errors++;
        $display("FAIL mon8_unexpected_bit: got q=%b first=%b last=%b expected no bit at %0t",
                 q8, first8, last8, $time);
      end else begin
        if ({q8, first8, last8} !== sb8[0]) begin
          errors++;
          $display("FAIL mon8_bit: got %b expected %b at %0t", {q8, first8, last8}, sb8[0], $time);
        end
        if (en8) void'(sb8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (ov5 === 1'b1) begin
      checks++;
      if (sb5.size() == 0) begin
        errors++;
        $display("FAIL mon5_unexpected_bit: got q=%b first=%b last=%b expected no bit at %0t",
                 q5, first5, last5, $time);
      end else begin
        if ({q5, first5, last5} !== sb5[0]) begin
          errors++;
          $display("FAIL mon5_bit: got %b expected %b at %0t", {q5, first5, last5}, sb5[0], $time);
        end
        if (en5) void'(sb5.pop_front());
      end
    end
  end

  int n_valid;
  int n_last;
  bit contiguous;

  initial begin
    rst8 = 1'b1; valid8 = 1'b1; en8 = 1'b0; data8 = 8'h3C;
    rst5 = 1'b1; valid5 = 1'b0; en5 = 1'b0; data5 = 5'h00;

    // Test 1: reset held two cycles with i_valid high
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      chk("t1_rst_ready", {31'd0, ready8}, 32'd0);
      chk("t1_rst_valid", {31'd0, ov8}, 32'd0);
    end
    tick();
    rst8 = 1'b0; rst5 = 1'b0; valid8 = 1'b0; #1;
    chk("t1_rel_ready", {31'd0, ready8}, 32'd1);
    chk("t1_rel_valid", {31'd0, ov8}, 32'd0);
    chk("t1_rel_q", {29'd0, q8, first8, last8}, 32'd0);
    chk("t1_rel_ready5", {31'd0, ready5}, 32'd1);

    // Test 2: 0xA5 with i_en=1 throughout
    tick();
    valid8 = 1'b1; data8 = 8'hA5; en8 = 1'b1; #1;
    chk("t2_accept_ready", {31'd0, ready8}, 32'd1);
    push8(8'hA5);
    tick();
    valid8 = 1'b0; data8 = 8'h00; #1;
    chk("t2_first_valid", {31'd0, ov8}, 32'd1);
    chk("t2_first_flag", {31'd0, first8}, 32'd1);
    chk("t2_first_q", {31'd0, q8}, 32'd1);
    for (int c = 2; c <= 8; c++) begin
      tick(); #1;
      if (c == 8) chk("t2_last_flag", {31'd0, last8}, 32'd1);
    end
    tick(); #1;
    chk("t2_done_valid", {31'd0, ov8}, 32'd0);
    chk("t2_sb_empty", sb8.size(), 32'd0);

    // Test 3: 0xA5 with i_en alternating 0,1
    tick();
    valid8 = 1'b1; data8 = 8'hA5; en8 = 1'b0;
    push8(8'hA5);
    n_valid = 0; n_last = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      valid8 = 1'b0;
      en8 = (c % 2 == 0);
      #1;
      if (ov8 === 1'b1) n_valid++;
      if (last8 === 1'b1) n_last++;
    end
    en8 = 1'b1;
    chk("t3_valid_cycles", n_valid, 32'd16);
    chk("t3_last_cycles", n_last, 32'd2);
    chk("t3_sb_empty", sb8.size(), 32'd0);

    // Test 4: i_valid held with 0x01, 0x80, 0xFF
    tick();
    valid8 = 1'b1; data8 = 8'h01; en8 = 1'b1; #1;
    chk("t4_acc0_ready", {31'd0, ready8}, 32'd1);
    push8(8'h01);
    tick();
    data8 = 8'h80; #1;
    chk("t4_acc1_ready", {31'd0, ready8}, 32'd1);
    push8(8'h80);
    for (int c = 2; c <= 8; c++) begin
      tick();
      data8 = 8'hFF; #1;
      chk("t4_stall_ready", {31'd0, ready8}, 32'd0);
    end
    tick(); #1;
    chk("t4_acc2_ready", {31'd0, ready8}, 32'd1);
    push8(8'hFF);
    contiguous = 1'b1;
    for (int c = 10; c <= 24; c++) begin
      tick();
      valid8 = 1'b0; data8 = 8'h00; #1;
      if (ov8 !== 1'b1) contiguous = 1'b0;
    end
    chk("t4_contiguous", {31'd0, contiguous}, 32'd1);
    tick(); #1;
    chk("t4_done_valid", {31'd0, ov8}, 32'd0);
    chk("t4_sb_empty", sb8.size(), 32'd0);

    // Test 5: reset during bit 3 with the buffer full
    tick();
    valid8 = 1'b1; data8 = 8'hFF; en8 = 1'b1;
    push8(8'hFF);
    tick();
    push8(8'hFF);
    tick();
    valid8 = 1'b0; #1;
    chk("t5_hold_full", {31'd0, ready8}, 32'd0);
    tick();
    tick();
    rst8 = 1'b1; valid8 = 1'b1; #1;
    chk("t5_bit3_valid", {31'd0, ov8}, 32'd1);
    tick();
    sb8.delete(); #1;
    chk("t5_rst_valid", {31'd0, ov8}, 32'd0);
    chk("t5_rst_ready", {31'd0, ready8}, 32'd0);
    tick();
    rst8 = 1'b0; valid8 = 1'b0; #1;
    chk("t5_rel_ready", {31'd0, ready8}, 32'd1);
    n_valid = 0;
    for (int c = 0; c < 20; c++) begin
      tick(); #1;
      if (ov8 !== 1'b0) n_valid++;
    end
    chk("t5_no_residual", n_valid, 32'd0);

    // Test 6: WIDTH=5, 0x13 stalled for 10 cycles then streamed
    tick();
    valid5 = 1'b1; data5 = 5'h13; en5 = 1'b0;
    push5(5'h13);
    for (int c = 0; c < 10; c++) begin
      tick();
      valid5 = 1'b0; data5 = 5'h00; #1;
      chk("t6_stall_valid", {31'd0, ov5}, 32'd1);
      chk("t6_stall_first", {31'd0, first5}, 32'd1);
      chk("t6_stall_q", {31'd0, q5}, 32'd1);
    end
    en5 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick(); #1;
      if (c == 4) chk("t6_last5", {31'd0, last5}, 32'd1);
    end
    chk("t6_done_valid", {31'd0, ov5}, 32'd0);
    chk("t6_sb_empty", sb5.size(), 32'd0);

    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
